// File: rtl/gesture_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gesture_command_scheduler
// Brief    : Qualifies classifier gestures, arbitrates them against the button
//            pad and releases frame-aligned, rate-limited decoder commands.
// Revision : 1.0 - initial release
// ============================================================================
module gesture_command_scheduler #(
    parameter int STABLE_COUNT   = 4,
    parameter int HOLDOFF_FRAMES = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable_in,
    input  logic       gest_valid_in,
    input  logic [3:0] gest_code_in,
    input  logic       btn_valid_in,
    input  logic [3:0] btn_code_in,
    input  logic       frame_start_in,
    output logic       cmd_valid_out,
    output logic [3:0] cmd_out,
    output logic       busy_out,
    output logic       source_out
);

    localparam int              c_SW          = $clog2(STABLE_COUNT + 1);
    localparam int              c_HW          = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [c_SW-1:0] c_STAB_MAX    = c_SW'(STABLE_COUNT);
    localparam logic [c_SW-1:0] c_STAB_ONE    = c_SW'(1);
    localparam logic [c_HW-1:0] c_HOLD_INIT   = c_HW'(HOLDOFF_FRAMES);
    localparam logic [c_HW-1:0] c_HOLD_ONE    = c_HW'(1);
    localparam logic [3:0]      c_CODE_FILTER = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_ISSUE      = 2'd2,
        S_HOLDOFF    = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cand_code;
    logic [c_SW-1:0] r_stab_cnt;
    logic [3:0]      r_btn_code_q;
    logic [3:0]      r_pend_code;
    logic [c_HW-1:0] r_hold_cnt;
    logic            r_fm_lock;

    logic w_cand_cmd;
    logic w_btn_cmd;
    logic w_gest_qual;
    logic w_gest_req;
    logic w_btn_req;
    logic w_fm_src;

    assign w_cand_cmd  = (r_cand_code >= 4'd1) && (r_cand_code <= 4'd5);
    assign w_btn_cmd   = (r_btn_code_q >= 4'd1) && (r_btn_code_q <= 4'd5);
    assign w_gest_qual = (r_stab_cnt == c_STAB_MAX) && w_cand_cmd;
    assign w_gest_req  = w_gest_qual && !(r_fm_lock && (r_cand_code == c_CODE_FILTER));
    assign w_btn_req   = w_btn_cmd && !(r_fm_lock && (r_btn_code_q == c_CODE_FILTER));
    // Filter source still asserted: keeps the one-shot lock armed until release.
    assign w_fm_src    = (w_gest_qual && (r_cand_code == c_CODE_FILTER)) ||
                         (r_btn_code_q == c_CODE_FILTER);

    // Qualifier and button register run regardless of FSM state or enable.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_cand_code  <= 4'd0;
            r_stab_cnt   <= '0;
            r_btn_code_q <= 4'd0;
        end else begin
            if (gest_valid_in) begin
                if (gest_code_in == r_cand_code) begin
                    if (r_stab_cnt != c_STAB_MAX) begin
                        r_stab_cnt <= r_stab_cnt + c_STAB_ONE;
                    end
                end else begin
                    r_cand_code <= gest_code_in;
                    r_stab_cnt  <= c_STAB_ONE;
                end
            end
            if (btn_valid_in) begin
                r_btn_code_q <= btn_code_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_pend_code   <= 4'd0;
            r_hold_cnt    <= '0;
            r_fm_lock     <= 1'b0;
            cmd_valid_out <= 1'b0;
            cmd_out       <= 4'd0;
            busy_out      <= 1'b0;
            source_out    <= 1'b0;
        end else begin
            cmd_valid_out <= 1'b0;

            if ((r_state == S_ISSUE) && (r_pend_code == c_CODE_FILTER)) begin
                r_fm_lock <= 1'b1;
            end else if (!w_fm_src) begin
                r_fm_lock <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable_in && (w_btn_req || w_gest_req)) begin
                        r_pend_code <= w_btn_req ? r_btn_code_q : r_cand_code;
                        source_out  <= w_btn_req;
                        busy_out    <= 1'b1;
                        r_state     <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (!enable_in) begin
                        busy_out <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (frame_start_in) begin
                        cmd_valid_out <= 1'b1;
                        cmd_out       <= r_pend_code;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_hold_cnt <= c_HOLD_INIT;
                    if (HOLDOFF_FRAMES == 0) begin
                        busy_out <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_state  <= S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (frame_start_in) begin
                        r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
                        if (r_hold_cnt <= c_HOLD_ONE) begin
                            busy_out <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gesture_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gesture_command_scheduler
// Brief    : Scenario bench for gesture_command_scheduler with an expected-command queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gesture_command_scheduler;

    localparam int STABLE_COUNT   = 4;
    localparam int HOLDOFF_FRAMES = 2;

    logic       clk_in         = 1'b0;
    logic       rst_n_in       = 1'b0;
    logic       enable_in      = 1'b1;
    logic       gest_valid_in  = 1'b0;
    logic [3:0] gest_code_in   = 4'd0;
    logic       btn_valid_in   = 1'b0;
    logic [3:0] btn_code_in    = 4'd0;
    logic       frame_start_in = 1'b0;
    logic       cmd_valid_out;
    logic [3:0] cmd_out;
    logic       busy_out;
    logic       source_out;

    typedef struct packed {
        logic [3:0] code;
        logic       src;
    } exp_t;

    exp_t sb[$];
    exp_t r_exp;
    int   checks      = 0;
    int   errors      = 0;
    int   strobe_cnt  = 0;
    int   exp_strobes = 0;

    gesture_command_scheduler #(
        .STABLE_COUNT   (STABLE_COUNT),
        .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .enable_in      (enable_in),
        .gest_valid_in  (gest_valid_in),
        .gest_code_in   (gest_code_in),
        .btn_valid_in   (btn_valid_in),
        .btn_code_in    (btn_code_in),
        .frame_start_in (frame_start_in),
        .cmd_valid_out  (cmd_valid_out),
        .cmd_out        (cmd_out),
        .busy_out       (busy_out),
        .source_out     (source_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (cmd_valid_out === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic btn_strobe(input logic [3:0] code);
        btn_valid_in = 1'b1;
        btn_code_in  = code;
        cyc(1);
        btn_valid_in = 1'b0;
    endtask

    task automatic gest_strobe(input logic [3:0] code);
        gest_valid_in = 1'b1;
        gest_code_in  = code;
        cyc(1);
        gest_valid_in = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start_in = 1'b1;
        cyc(1);
        frame_start_in = 1'b0;
    endtask

    task automatic expect_cmd(input logic [3:0] code, input logic src);
        sb.push_back('{code: code, src: src});
        exp_strobes++;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        cyc(3);
        checks++;
        if ({cmd_valid_out, cmd_out, busy_out, source_out} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b cmd=%0d busy=%b src=%b, expected all 0",
                     cmd_valid_out, cmd_out, busy_out, source_out);
        end
        rst_n_in = 1'b1;
        cyc(2);
    endtask

    task automatic test_button_issue();
        btn_strobe(4'd2);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL btn_latency_early: busy=%b expected 0", busy_out);
        end
        expect_cmd(4'd2, 1'b1);
        cyc(1);
        checks++;
        if (busy_out !== 1'b1 || source_out !== 1'b1) begin
            errors++; $display("FAIL btn_latch: busy=%b src=%b expected 1/1", busy_out, source_out);
        end
        btn_strobe(4'd0);
        cyc(8);
        checks++;
        if (cmd_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++; $display("FAIL btn_wait: valid=%b busy=%b expected 0/1", cmd_valid_out, busy_out);
        end
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL btn_strobe: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL btn_cmd: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(1);
        checks++;
        if (cmd_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++; $display("FAIL btn_pulse_width: valid=%b busy=%b expected 0/1", cmd_valid_out, busy_out);
        end
        cyc(3);
        frame_pulse();
        checks++;
        if (busy_out !== 1'b1) begin
            errors++; $display("FAIL btn_holdoff1: busy=%b expected 1", busy_out);
        end
        cyc(3);
        frame_pulse();
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL btn_holdoff2: busy=%b expected 0", busy_out);
        end
        cyc(2);
    endtask

    task automatic test_back_to_back();
        btn_strobe(4'd1);
        expect_cmd(4'd1, 1'b1);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++; $display("FAIL b2b_latch_frame: valid=%b busy=%b expected 0/1", cmd_valid_out, busy_out);
        end
        btn_strobe(4'd0);
        frame_start_in = 1'b1;
        cyc(1);
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL b2b_strobe: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL b2b_cmd: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(1);
        frame_start_in = 1'b0;
        cyc(2);
        frame_pulse();
        checks++;
        if (busy_out !== 1'b1) begin
            errors++; $display("FAIL b2b_issue_frame_ignored: busy=%b expected 1", busy_out);
        end
        cyc(2);
        frame_pulse();
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL b2b_holdoff_end: busy=%b expected 0", busy_out);
        end
        cyc(2);
    endtask

    task automatic test_gesture_qual();
        gest_strobe(4'd3); gest_strobe(4'd3); gest_strobe(4'd3);
        gest_strobe(4'd4); gest_strobe(4'd4); gest_strobe(4'd4);
        cyc(2);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL gest_early_req: busy=%b expected 0", busy_out);
        end
        gest_strobe(4'd4);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL gest_latency: busy=%b expected 0", busy_out);
        end
        expect_cmd(4'd4, 1'b0);
        gest_strobe(4'd0);
        checks++;
        if (busy_out !== 1'b1 || source_out !== 1'b0) begin
            errors++; $display("FAIL gest_latch: busy=%b src=%b expected 1/0", busy_out, source_out);
        end
        cyc(2);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL gest_strobe: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL gest_cmd: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(2); frame_pulse(); cyc(2); frame_pulse(); cyc(2);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL gest_release: busy=%b expected 0", busy_out);
        end
    endtask

    task automatic test_arbitration();
        gest_strobe(4'd3); gest_strobe(4'd3); gest_strobe(4'd3);
        gest_valid_in = 1'b1; gest_code_in = 4'd3;
        btn_valid_in  = 1'b1; btn_code_in  = 4'd1;
        cyc(1);
        gest_valid_in = 1'b0; btn_valid_in = 1'b0;
        expect_cmd(4'd1, 1'b1);
        cyc(1);
        checks++;
        if (busy_out !== 1'b1 || source_out !== 1'b1) begin
            errors++; $display("FAIL arb_button_wins: busy=%b src=%b expected 1/1", busy_out, source_out);
        end
        btn_strobe(4'd0);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL arb_strobe1: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL arb_cmd1: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(2); frame_pulse(); cyc(2); frame_pulse();
        expect_cmd(4'd3, 1'b0);
        gest_strobe(4'd0);
        checks++;
        if (busy_out !== 1'b1 || source_out !== 1'b0) begin
            errors++; $display("FAIL arb_gesture_relatch: busy=%b src=%b expected 1/0", busy_out, source_out);
        end
        cyc(2);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL arb_strobe2: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL arb_cmd2: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(2); frame_pulse(); cyc(2); frame_pulse(); cyc(2);
    endtask

    task automatic test_filter_oneshot();
        btn_strobe(4'd5);
        expect_cmd(4'd5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(2);
            frame_pulse();
            if (i == 0) begin
                checks++;
                if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
                    errors++; $display("FAIL filt_strobe1: valid=%b expected 1", cmd_valid_out);
                end else begin
                    r_exp = sb.pop_front();
                    checks++;
                    if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                        errors++; $display("FAIL filt_cmd1: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
                    end
                end
            end
        end
        cyc(2);
        checks++;
        if (busy_out !== 1'b0 || strobe_cnt != exp_strobes) begin
            errors++; $display("FAIL filt_held_once: busy=%b strobes=%0d expected 0/%0d", busy_out, strobe_cnt, exp_strobes);
        end
        btn_strobe(4'd0);
        cyc(2);
        btn_strobe(4'd5);
        expect_cmd(4'd5, 1'b1);
        cyc(1);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++; $display("FAIL filt_rearm: busy=%b expected 1", busy_out);
        end
        btn_strobe(4'd0);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL filt_strobe2: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL filt_cmd2: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(2); frame_pulse(); cyc(2); frame_pulse(); cyc(2);
    endtask

    task automatic test_enable_abort();
        btn_strobe(4'd2);
        cyc(1);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++; $display("FAIL en_latch: busy=%b expected 1", busy_out);
        end
        enable_in = 1'b0;
        cyc(1);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL en_abort: busy=%b expected 0", busy_out);
        end
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b0) begin
            errors++; $display("FAIL en_no_strobe: valid=%b expected 0", cmd_valid_out);
        end
        cyc(3);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL en_no_accept: busy=%b expected 0", busy_out);
        end
        btn_strobe(4'd0);
        enable_in = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset_holdoff();
        btn_strobe(4'd4);
        expect_cmd(4'd4, 1'b1);
        cyc(1);
        btn_strobe(4'd0);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL rst_strobe1: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL rst_cmd1: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(2);
        rst_n_in = 1'b0;
        cyc(1);
        rst_n_in = 1'b1;
        checks++;
        if ({cmd_valid_out, cmd_out, busy_out, source_out} !== 7'd0) begin
            errors++;
            $display("FAIL rst_mid_holdoff: valid=%b cmd=%0d busy=%b src=%b expected all 0",
                     cmd_valid_out, cmd_out, busy_out, source_out);
        end
        btn_strobe(4'd1);
        expect_cmd(4'd1, 1'b1);
        cyc(1);
        btn_strobe(4'd0);
        frame_pulse();
        checks++;
        if (cmd_valid_out !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL rst_strobe2: valid=%b expected 1", cmd_valid_out);
        end else begin
            r_exp = sb.pop_front();
            checks++;
            if (cmd_out !== r_exp.code || source_out !== r_exp.src) begin
                errors++; $display("FAIL rst_cmd2: cmd=%0d src=%b expected %0d/%b", cmd_out, source_out, r_exp.code, r_exp.src);
            end
        end
        cyc(2); frame_pulse(); cyc(2); frame_pulse(); cyc(3);
        checks++;
        if (busy_out !== 1'b0 || strobe_cnt != exp_strobes || sb.size() != 0) begin
            errors++;
            $display("FAIL final_totals: busy=%b strobes=%0d pending=%0d expected 0/%0d/0",
                     busy_out, strobe_cnt, sb.size(), exp_strobes);
        end
    endtask

    initial begin
        test_reset();
        test_button_issue();
        test_back_to_back();
        test_gesture_qual();
        test_arbitration();
        test_filter_oneshot();
        test_enable_abort();
        test_reset_holdoff();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gesture_command_scheduler.md
# gesture_command_scheduler

Sits between the hand-gesture classifier and the hand-signal decoder, which holds the pan offsets and filter mode. It does three things:
- Qualifies noisy per-sample gesture codes.
- Arbitrates them against the manual button pad, with the button taking priority.
- Releases at most one command per rate-limit window, aligned to frame start, so pan and filter changes never land mid-frame.

It drives the decoder's one-cycle `new_data_in`/`data_in` pair.

## Interface
- `STABLE_COUNT`, 4: consecutive identical gesture samples needed to qualify a gesture (≥1).
- `HOLDOFF_FRAMES`, 2: frame starts to wait after an issued command before the next may be accepted (≥0).
- `clk_in` in 1: single system clock.
- `rst_n_in` in 1: reset, synchronous, active-low.
- `enable_in` in 1: when low, new commands are neither accepted nor issued.
- `gest_valid_in` in 1: classifier sample strobe.
- `gest_code_in` in 4: classifier code. 0 = none, 1 = up, 2 = down, 3 = left, 4 = right, 5 = filter change, 6–15 = none.
- `btn_valid_in` in 1: button pad update strobe (input is already debounced).
- `btn_code_in` in 4: button code, same encoding as `gest_code_in`.
- `frame_start_in` in 1: one-cycle pulse at the start of vertical blanking.
- `cmd_valid_out` out 1: one-cycle command strobe, drives the decoder's `new_data_in`.
- `cmd_out` out 4: command code, drives the decoder's `data_in`.
- `busy_out` out 1: high whenever the FSM is not in IDLE.
- `source_out` out 1: source of the latched or last command (0 = gesture, 1 = button).

## Operation
- **Gesture qualifier** (registers `cand_code`, `stab_cnt`; `stab_cnt` width is $clog2(STABLE_COUNT+1)).
  - On `gest_valid_in`: if `gest_code_in == cand_code`, `stab_cnt` increments, saturating at STABLE_COUNT.
  - Otherwise `cand_code <= gest_code_in` and `stab_cnt <= 1`.
  - `gest_req` = (`stab_cnt == STABLE_COUNT`) and `cand_code` in 1..5.
- **Button register** `btn_code_q`: loads `btn_code_in` on `btn_valid_in` and holds until the next strobe. `btn_req` = `btn_code_q` in 1..5.
- **Filter one-shot lock** `fm_lock`:
  - Set when code 5 is issued.
  - Cleared in any cycle where neither `cand_code` (if qualified) nor `btn_code_q` equals 5.
  - While set, any request for code 5 is masked out of `gest_req`/`btn_req`.
- **FSM states:** IDLE, WAIT_FRAME, ISSUE, HOLDOFF.
  - **IDLE:** if `enable_in` and (`btn_req` | `gest_req`), latch `pend_code` (button wins if both request) and `pend_src`, then go to WAIT_FRAME.
  - **WAIT_FRAME:** if `enable_in` is low, go to IDLE with no issue. Else, on `frame_start_in`, go to ISSUE. `pend_code` is frozen: source changes after latching do not alter it.
  - **ISSUE:** lasts exactly one cycle. `cmd_valid_out = 1`, `cmd_out = pend_code`. Load `hold_cnt <= HOLDOFF_FRAMES`. Go to HOLDOFF, or straight to IDLE if HOLDOFF_FRAMES = 0.
  - **HOLDOFF:** each `frame_start_in` decrements `hold_cnt`. When it reaches 0, go to IDLE. The countdown continues even if `enable_in` is low.
- The qualifier and button register run in every state; only the FSM is gated.
- A held movement gesture therefore repeats once per (HOLDOFF_FRAMES + 1) frames. Filter change fires once per hold.

## Timing
- **Reset** (`rst_n_in` low at an edge) clears everything at that edge:
  - Outputs: `cmd_valid_out = 0`, `cmd_out = 0`, `busy_out = 0`, `source_out = 0`.
  - Internal: FSM = IDLE; `cand_code`, `stab_cnt`, `btn_code_q`, `fm_lock`, `hold_cnt`, `pend_code` all 0.
- Reset mid-WAIT_FRAME or mid-HOLDOFF drops the pending command with no strobe.
- All outputs are registered. `cmd_valid_out` is high only in the cycle after the edge at which `frame_start_in` was sampled in WAIT_FRAME.
- **Latency from `btn_valid_in` at edge N:**
  - `btn_code_q` is valid after edge N.
  - IDLE latches at edge N+1, so the FSM is in WAIT_FRAME from N+1.
  - Strobe appears one cycle after the first `frame_start_in` seen at or after edge N+2.
- **Gesture latency:** `gest_req` rises after the edge sampling the STABLE_COUNT-th identical strobe.
- **Simultaneous events:**
  - `frame_start_in` during ISSUE is ignored (it does not decrement `hold_cnt`).
  - `frame_start_in` in the same cycle as the IDLE→WAIT_FRAME transition does not count; the next frame start is used.
  - `gest_valid_in` with a different code in the same cycle as a qualified request latching in IDLE still latches the old `cand_code`.

## Test plan
- **Button issue:** button code 2 strobed, then `frame_start_in` 10 cycles later → exactly one `cmd_valid_out` pulse with `cmd_out = 2` and `source_out = 1`, one cycle after the frame start. `busy_out` stays high through 2 more frame starts, then drops.
- **Gesture qualification:** gesture samples 3,3,3,4,4,4,4 with STABLE_COUNT = 4 → no request until the 4th consecutive 4. Then one command 4 with `source_out = 0` at the next frame start.
- **Arbitration:** button 1 and qualified gesture 3 present together in IDLE → `cmd_out = 1`. A gesture of 3 still held after holdoff, with the button released to 0 → next command is 3.
- **Filter one-shot:** button held at 5 for 10 frames → exactly one command 5. Button to 0, then 5 again → a second command 5.
- **Enable abort:** `enable_in` dropped during WAIT_FRAME → no strobe at the next frame start; FSM back in IDLE.
- **Reset mid-HOLDOFF:** `rst_n_in` low for 1 cycle during HOLDOFF → all outputs 0 next cycle. A fresh button request afterwards issues normally.
